// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine driving a single shared memory port.
// Optional fill mode (constant write, no reads) is compiled in with DMA_FILL_EN.
module mem_copy_dma (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [10:0] len,
  input  logic        fill,
  input  logic [31:0] fill_value,
  output logic [15:0] mem_raddr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  output logic [15:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic        busy,
  output logic        done,
  output logic [10:0] word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [9:0]  src_ptr, dst_ptr;
  logic [10:0] len_q;
  logic [10:0] len_clamped;
  logic        fill_q;
  logic        fill_sel;
  logic [31:0] fill_data;
  logic        last_word;
  logic        unused_bits;

  // Fill mode only exists when the feature is built in; otherwise those ports are dead.
`ifdef DMA_FILL_EN
  assign fill_sel    = fill;
  assign fill_data   = fill_value;
  assign unused_bits = ^{src_addr[15:10], dst_addr[15:10]};
`else
  assign fill_sel    = 1'b0;
  assign fill_data   = 32'd0;
  assign unused_bits = ^{fill, fill_value, src_addr[15:10], dst_addr[15:10]};
`endif

  assign len_clamped = (len > 11'd1024) ? 11'd1024 : len;
  assign last_word   = ((word_count + 11'd1) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_ptr    <= 10'd0;
      dst_ptr    <= 10'd0;
      len_q      <= 11'd0;
      fill_q     <= 1'b0;
      word_count <= 11'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr    <= src_addr[9:0];
            dst_ptr    <= dst_addr[9:0];
            len_q      <= len_clamped;
            fill_q     <= fill_sel;
            word_count <= 11'd0;
          end
        end
        WRITE: begin
          // 10-bit pointers wrap 1023 -> 0 naturally
          src_ptr    <= src_ptr + 10'd1;
          dst_ptr    <= dst_ptr + 10'd1;
          word_count <= word_count + 11'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    next_state = state;
    mem_raddr  = 16'd0;
    mem_ren    = 1'b0;
    mem_waddr  = 16'd0;
    mem_wdata  = 32'd0;
    mem_wen    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamped == 11'd0) next_state = DONE;
          else if (fill_sel)        next_state = WRITE;
          else                      next_state = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        mem_ren    = 1'b1;
        mem_raddr  = {6'b0, src_ptr};
        next_state = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_wen   = 1'b1;
        mem_waddr = {6'b0, dst_ptr};
        mem_wdata = fill_q ? fill_data : mem_rdata;
        if (last_word)   next_state = DONE;
        else if (fill_q) next_state = WRITE;
        else             next_state = READ;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: stimulus queues expected memory traffic and
// done timing, a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_copy_dma;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wrExp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] srcAddr, dstAddr;
  logic [10:0] len;
  logic        fill;
  logic [31:0] fillValue;
  logic [15:0] memRaddr, memWaddr;
  logic        memRen, memWen;
  logic [31:0] memRdata, memWdata;
  logic        busy, done;
  logic [10:0] wordCount;

  logic [31:0] memArr [0:1023];
  logic        initReq = 1'b0;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int renCount = 0;
  int wenCount = 0;
  int doneCount = 0;

  logic [15:0] rq [$];
  wrExp_t      wq [$];
  int          dq [$];
  wrExp_t      wPop;

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(srcAddr), .dst_addr(dstAddr), .len(len),
    .fill(fill), .fill_value(fillValue),
    .mem_raddr(memRaddr), .mem_ren(memRen), .mem_rdata(memRdata),
    .mem_waddr(memWaddr), .mem_wdata(memWdata), .mem_wen(memWen),
    .busy(busy), .done(done), .word_count(wordCount)
  );

  // Synchronous memory with read priority, plus a bulk mem[i]=i initialiser
  always @(posedge clk) begin
    if (initReq) begin
      for (int i = 0; i < 1024; i++) memArr[i] <= 32'(i);
    end else if (memRen) begin
      memRdata <= memArr[memRaddr[9:0]];
    end else if (memWen) begin
      memArr[memWaddr[9:0]] <= memWdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a read, write or done
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("ren_wen_exclusive", 64'(memRen & memWen), 64'd0);
      if (memRen) begin
        renCount++;
        if (rq.size() == 0) checkOutput("unexpected_read", 64'(memRaddr), 64'hFFFF_FFFF);
        else checkOutput("read_addr", 64'(memRaddr), 64'(rq.pop_front()));
      end else begin
        checkOutput("raddr_zero", 64'(memRaddr), 64'd0);
      end
      if (memWen) begin
        wenCount++;
        if (wq.size() == 0) begin
          checkOutput("unexpected_write", 64'(memWaddr), 64'hFFFF_FFFF);
        end else begin
          wPop = wq.pop_front();
          checkOutput("write_addr", 64'(memWaddr), 64'(wPop.addr));
          checkOutput("write_data", 64'(memWdata), 64'(wPop.data));
        end
      end else begin
        checkOutput("waddr_wdata_zero", {memWaddr, memWdata}, 64'd0);
      end
      if (done) begin
        doneCount++;
        checkOutput("busy_in_done", 64'(busy), 64'd0);
        if (dq.size() == 0) checkOutput("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
        else checkOutput("done_cycle", 64'(cyc), 64'(dq.pop_front()));
      end
    end
  end

  task automatic initMem();
    @(negedge clk) initReq = 1'b1;
    @(negedge clk) initReq = 1'b0;
  endtask

  task automatic expectCopy(input int srcIdx, input int dstIdx, input int n);
    for (int k = 0; k < n; k++) begin
      rq.push_back(16'((srcIdx + k) % 1024));
      wq.push_back('{addr: 16'((dstIdx + k) % 1024), data: 32'((srcIdx + k) % 1024)});
    end
  endtask

  // Caller is at a negedge; start is held for exactly one sampling edge
  task automatic applyStimulus(input logic [15:0] s, input logic [15:0] d, input logic [10:0] l,
                               input logic f, input logic [31:0] fv, input int expLat);
    srcAddr   = s;
    dstAddr   = d;
    len       = l;
    fill      = f;
    fillValue = fv;
    start     = 1'b1;
    if (expLat >= 0) dq.push_back(cyc + expLat);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, input string name);
    int snap = doneCount;
    int n = 0;
    while (doneCount == snap && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (doneCount == snap) checkOutput({name, "_timeout"}, 64'd1, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int renSnap, wenSnap, doneSnap;
    rst_n = 1'b0; start = 1'b0; srcAddr = '0; dstAddr = '0; len = '0;
    fill = 1'b0; fillValue = '0;
    #12;
    checkOutput("reset_outputs", {memRen, memWen, busy, done, memRaddr, memWaddr}, 64'd0);
    checkOutput("reset_word_count", 64'(wordCount), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    initMem();

    // Basic copy, mem[i]=i
    @(negedge clk);
    expectCopy(0, 512, 4);
    applyStimulus(16'd0, 16'd512, 11'd4, 1'b0, 32'd0, 9);
    waitDone(40, "basic");
    checkOutput("basic_word_count", 64'(wordCount), 64'd4);
    for (int i = 0; i < 4; i++) checkOutput("basic_mem", 64'(memArr[512 + i]), 64'(i));

    // Zero length: done next cycle, no memory traffic
    renSnap = renCount; wenSnap = wenCount;
    @(negedge clk);
    applyStimulus(16'd5, 16'd6, 11'd0, 1'b0, 32'd0, 1);
    waitDone(10, "len0");
    checkOutput("len0_no_traffic", 64'((renCount - renSnap) + (wenCount - wenSnap)), 64'd0);
    checkOutput("len0_word_count", 64'(wordCount), 64'd0);

    // Source pointer wraps 1023 -> 0
    initMem();
    @(negedge clk);
    expectCopy(1022, 100, 4);
    applyStimulus(16'd1022, 16'd100, 11'd4, 1'b0, 32'd0, 9);
    waitDone(40, "wrap");
    checkOutput("wrap_mem100", 64'(memArr[100]), 64'd1022);
    checkOutput("wrap_mem103", 64'(memArr[103]), 64'd1);

    // Upper address bits are ignored
    initMem();
    @(negedge clk);
    expectCopy(3, 16, 2);
    applyStimulus(16'h8403, 16'h0C10, 11'd2, 1'b0, 32'd0, 5);
    waitDone(30, "upper");
    checkOutput("upper_word_count", 64'(wordCount), 64'd2);

    // Overlap with dst>src propagates the first word
    initMem();
    @(negedge clk);
    rq.push_back(16'd600); wq.push_back('{addr: 16'd601, data: 32'd600});
    rq.push_back(16'd601); wq.push_back('{addr: 16'd602, data: 32'd600});
    rq.push_back(16'd602); wq.push_back('{addr: 16'd603, data: 32'd600});
    applyStimulus(16'd600, 16'd601, 11'd3, 1'b0, 32'd0, 7);
    waitDone(30, "overlap");
    checkOutput("overlap_mem603", 64'(memArr[603]), 64'd600);

    // Start while busy is ignored
    initMem();
    doneSnap = doneCount;
    @(negedge clk);
    expectCopy(10, 700, 3);
    applyStimulus(16'd10, 16'd700, 11'd3, 1'b0, 32'd0, 7);
    @(negedge clk);
    applyStimulus(16'd50, 16'd800, 11'd2, 1'b0, 32'd0, -1);
    waitDone(30, "busy_start");
    repeat (10) @(negedge clk);
    checkOutput("busy_start_one_done", 64'(doneCount - doneSnap), 64'd1);
    checkOutput("busy_start_mem800", 64'(memArr[800]), 64'd800);

    // Length above 1024 clamps to 1024
    initMem();
    @(negedge clk);
    expectCopy(0, 0, 1024);
    applyStimulus(16'd0, 16'd0, 11'd1500, 1'b0, 32'd0, 2049);
    waitDone(2100, "clamp");
    checkOutput("clamp_word_count", 64'(wordCount), 64'd1024);

    // Reset during the third WRITE aborts after two words
    initMem();
    doneSnap = doneCount;
    @(negedge clk);
    expectCopy(200, 300, 2);
    rq.push_back(16'd202);
    applyStimulus(16'd200, 16'd300, 11'd8, 1'b0, 32'd0, -1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", {memRen, memWen, busy, done, memRaddr, memWaddr}, 64'd0);
    checkOutput("abort_wdata", 64'(memWdata), 64'd0);
    checkOutput("abort_word_count", 64'(wordCount), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", 64'(doneCount - doneSnap), 64'd0);
    checkOutput("abort_mem301", 64'(memArr[301]), 64'd201);
    checkOutput("abort_mem302", 64'(memArr[302]), 64'd302);
    rst_n = 1'b1;
    expectCopy(20, 40, 1);
    applyStimulus(16'd20, 16'd40, 11'd1, 1'b0, 32'd0, 3);
    waitDone(20, "after_reset");
    checkOutput("after_reset_mem40", 64'(memArr[40]), 64'd20);

    // Fill request: constant writes when built in, plain copy otherwise
    initMem();
    renSnap = renCount;
    @(negedge clk);
`ifdef DMA_FILL_EN
    for (int k = 0; k < 3; k++) wq.push_back('{addr: 16'(10 + k), data: 32'hDEADBEEF});
    applyStimulus(16'd77, 16'd10, 11'd3, 1'b1, 32'hDEADBEEF, 4);
    waitDone(20, "fill");
    checkOutput("fill_no_reads", 64'(renCount - renSnap), 64'd0);
    checkOutput("fill_mem12", 64'(memArr[12]), 64'hDEADBEEF);
`else
    expectCopy(77, 10, 3);
    applyStimulus(16'd77, 16'd10, 11'd3, 1'b1, 32'hDEADBEEF, 7);
    waitDone(30, "fill_ignored");
    checkOutput("fill_ignored_reads", 64'(renCount - renSnap), 64'd3);
    checkOutput("fill_ignored_mem12", 64'(memArr[12]), 64'd79);
`endif
    checkOutput("fill_word_count", 64'(wordCount), 64'd3);

    repeat (3) @(negedge clk);
    checkOutput("reads_drained", 64'(rq.size()), 64'd0);
    checkOutput("writes_drained", 64'(wq.size()), 64'd0);
    checkOutput("dones_drained", 64'(dq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are named as below.
REQ-002 clk  input  1  rising-edge clock, shared with the memory it drives.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a transfer; sampled only in IDLE.
REQ-005 src_addr  input  16  first source word address; bits [9:0] used.
REQ-006 dst_addr  input  16  first destination word address; bits [9:0] used.
REQ-007 len  input  11  words to transfer; values >1024 SHALL be clamped to 1024.
REQ-008 fill  input  1  fill-mode select at start; only active under DMA_FILL_EN.
REQ-009 fill_value  input  32  constant written in fill mode.
REQ-010 mem_raddr  output  16  memory read address.
REQ-011 mem_ren  output  1  memory read enable.
REQ-012 mem_rdata  input  32  memory read data, valid the cycle after mem_ren.
REQ-013 mem_waddr  output  16  memory write address.
REQ-014 mem_wdata  output  32  memory write data.
REQ-015 mem_wen  output  1  memory write enable.
REQ-016 busy  output  1  high in READ and WRITE.
REQ-017 done  output  1  one-cycle pulse at transfer end.
REQ-018 word_count  output  11  words written so far in the current or last transfer.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-020 In IDLE, start=1 SHALL latch src/dst (mod 1024), clamped len, and fill; clear word_count; go to READ, or to DONE if len=0.
REQ-021 In READ, the block SHALL drive mem_ren=1, mem_raddr={6'b0,src_ptr} and mem_wen=0, then go to WRITE.
REQ-022 In WRITE, the block SHALL drive mem_wen=1, mem_waddr={6'b0,dst_ptr}, mem_wdata=mem_rdata and mem_ren=0; it SHALL increment src_ptr, dst_ptr and word_count; it SHALL go to DONE when word_count+1 equals len, else READ.
REQ-023 mem_ren and mem_wen SHALL never be high in the same cycle, because the memory gives read priority.
REQ-024 Pointers SHALL wrap 1023 -> 0 using 10-bit arithmetic.
REQ-025 Copy order SHALL be strictly ascending; overlapping regions with dst>src SHALL propagate earlier-written words (no overlap detection).
REQ-026 DONE SHALL assert done for exactly one cycle and return to IDLE; busy SHALL be 0 in DONE.
REQ-027 Latency SHALL be 2*len+1 cycles from the start-sampling edge to the done cycle (1 cycle for len=0).
REQ-028 start while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-029 When mem_ren or mem_wen is low, the corresponding address/data outputs SHALL be 0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE with all outputs, pointers and word_count at 0, aborting any transfer mid-operation with no done pulse.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-032 Macro DMA_FILL_EN defined: fill=1 at start SHALL skip READ, writing fill_value on consecutive WRITE cycles (1 cycle/word, latency len+1), with mem_ren held 0.
REQ-033 DMA_FILL_EN undefined: fill and fill_value SHALL remain ports but be ignored, and every transfer SHALL be a copy.

Verification
REQ-034 src=0, dst=512, len=4 on a memory holding mem[i]=i -> mem[512..515]=0,1,2,3; done 9 cycles after start; word_count=4.
REQ-035 len=0 -> done on the next cycle; mem_ren/mem_wen never asserted.
REQ-036 src=1022, dst=100, len=4 -> reads 1022,1023,0,1; mem[100..103]=1022,1023,0,1.
REQ-037 rst_n pulsed low during the 3rd WRITE of len=8 -> outputs 0 immediately, no done, exactly 2 words written; a new start is then accepted.
REQ-038 start re-pulsed while busy -> ignored; exactly one done.
REQ-039 DMA_FILL_EN defined: fill=1, fill_value=32'hDEADBEEF, dst=10, len=3 -> mem[10..12]=DEADBEEF, mem_ren never high, done 4 cycles after start.
